execute_cycle: RTL and testbench

//  Execute stage of the 5-stage RV32 pipeline. Sits between the decode stage and the memory stage.
//  - Consumes the registered ID/EX bundle.
//  - Resolves operand forwarding, runs the ALU and computes the branch target.
//  - Drives PC redirect back to fetch combinationally.
//  - Registers the EX/MEM bundle for the memory stage.

---
 rtl/execute_cycle_pkg.sv | 13 +
 rtl/execute_cycle_if.sv | 25 ++
 rtl/execute_cycle_alu.sv | 17 +
 rtl/execute_cycle.sv | 55 +++++
 tb/tb_execute_cycle.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/execute_cycle_pkg.sv
// execute_cycle_pkg: shared widths, ALU op codes and forward-select codes for the RV32 execute stage
package rv_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/execute_cycle_if.sv
// execute_cycle_if: ID/EX bundle in, branch redirect and EX/MEM bundle out
interface execute_cycle_if import rv_pkg::*; #(parameter int DW = DATA_W, parameter int AW = REG_AW);
  logic          Reg_WriteE, Mem_WriteE, ALU_SrcE, Result_SrcE, BranchE;
  logic [2:0]    ALU_ControlE;
  logic [DW-1:0] RD1E, RD2E, Imm_ExE, PCE, PcPlusE, ResultW;
  logic [AW-1:0] RDE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          PCSrcE;
  logic [DW-1:0] PCTargetE;
  logic          Reg_WriteM, Mem_WriteM, Result_SrcM;
  logic [DW-1:0] ALU_ResultM, Write_DataM, PcPlusM;
  logic [AW-1:0] RDM;
  modport master (
    output Reg_WriteE, Mem_WriteE, ALU_SrcE, Result_SrcE, BranchE, ALU_ControlE,
           RD1E, RD2E, Imm_ExE, PCE, PcPlusE, RDE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, Reg_WriteM, Mem_WriteM, Result_SrcM,
           ALU_ResultM, Write_DataM, PcPlusM, RDM
  );
  modport slave (
    input  Reg_WriteE, Mem_WriteE, ALU_SrcE, Result_SrcE, BranchE, ALU_ControlE,
           RD1E, RD2E, Imm_ExE, PCE, PcPlusE, RDE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, Reg_WriteM, Mem_WriteM, Result_SrcM,
           ALU_ResultM, Write_DataM, PcPlusM, RDM
  );
endinterface

// File: rtl/execute_cycle_alu.sv
// alu: combinational RV32 ALU subset with zero flag; unknown op codes yield 0
module alu import rv_pkg::*; #(parameter int W = DATA_W) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ctrl,
  output logic [W-1:0] result,
  output logic         zero
);
  always_comb begin
    result = ctrl == ALU_ADD ? a + b :
             ctrl == ALU_SUB ? a - b :
             ctrl == ALU_AND ? a & b :
             ctrl == ALU_OR  ? a | b :
             ctrl == ALU_SLT ? W'($signed(a) < $signed(b)) : '0;
    zero = result == '0;
  end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage -- operand forwarding, ALU, branch resolve and EX/MEM register
module execute_cycle import rv_pkg::*; (
  input logic clk,
  input logic rst,
  execute_cycle_if.slave bus
);
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_src_b, w_alu_result;
  logic              w_zero;
  logic              r_reg_write, r_mem_write, r_result_src;
  logic [DATA_W-1:0] r_alu_result, r_write_data, r_pc_plus;
  logic [REG_AW-1:0] r_rd;
  // reserved select 2'b11 falls back to the register-file operand
  always_comb begin
    w_fwd_a = bus.ForwardAE == FWD_WB  ? bus.ResultW :
              bus.ForwardAE == FWD_MEM ? r_alu_result : bus.RD1E;
    w_fwd_b = bus.ForwardBE == FWD_WB  ? bus.ResultW :
              bus.ForwardBE == FWD_MEM ? r_alu_result : bus.RD2E;
    w_src_b = bus.ALU_SrcE ? bus.Imm_ExE : w_fwd_b;
  end
  alu #(.W(DATA_W)) u_alu (
    .a(w_fwd_a),
    .b(w_src_b),
    .ctrl(bus.ALU_ControlE),
    .result(w_alu_result),
    .zero(w_zero)
  );
  assign bus.PCSrcE    = bus.BranchE & w_zero & ~rst;
  assign bus.PCTargetE = bus.PCE + bus.Imm_ExE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus    <= '0;
      r_rd         <= '0;
    end else begin
      r_reg_write  <= bus.Reg_WriteE;
      r_mem_write  <= bus.Mem_WriteE;
      r_result_src <= bus.Result_SrcE;
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus    <= bus.PcPlusE;
      r_rd         <= bus.RDE;
    end
  end
  assign bus.Reg_WriteM  = r_reg_write;
  assign bus.Mem_WriteM  = r_mem_write;
  assign bus.Result_SrcM = r_result_src;
  assign bus.ALU_ResultM = r_alu_result;
  assign bus.Write_DataM = r_write_data;
  assign bus.PcPlusM     = r_pc_plus;
  assign bus.RDM         = r_rd;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed self-checking bench for the execute stage
module tb_execute_cycle;
  import rv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  execute_cycle_if bus ();
  execute_cycle dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Reg_WriteE = 0; bus.Mem_WriteE = 0; bus.ALU_SrcE = 0; bus.Result_SrcE = 0;
    bus.BranchE = 0; bus.ALU_ControlE = ALU_ADD; bus.RD1E = 0; bus.RD2E = 0;
    bus.Imm_ExE = 0; bus.PCE = 0; bus.PcPlusE = 0; bus.RDE = 0;
    bus.ForwardAE = FWD_REG; bus.ForwardBE = FWD_REG; bus.ResultW = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.Reg_WriteE = 1; bus.Mem_WriteE = 1; bus.Result_SrcE = 1; bus.BranchE = 1;
    bus.ALU_ControlE = ALU_SUB; bus.RD1E = 32'h55; bus.RD2E = 32'h55;
    bus.PCE = 32'h40; bus.PcPlusE = 32'h44; bus.RDE = 5'd9; bus.Imm_ExE = 32'h10;
    bus.ForwardAE = FWD_REG; bus.ForwardBE = FWD_REG; bus.ALU_SrcE = 0;
    tick();
    tick();
    checks++; if (bus.Reg_WriteM !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", bus.Reg_WriteM); end
    checks++; if (bus.Mem_WriteM !== 1'b0) begin failures++; $display("FAIL reset_memwrite got=%0b exp=0", bus.Mem_WriteM); end
    checks++; if (bus.Result_SrcM !== 1'b0) begin failures++; $display("FAIL reset_resultsrc got=%0b exp=0", bus.Result_SrcM); end
    checks++; if (bus.ALU_ResultM !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", bus.ALU_ResultM); end
    checks++; if (bus.Write_DataM !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.Write_DataM); end
    checks++; if (bus.PcPlusM !== 32'h0) begin failures++; $display("FAIL reset_pcplus got=%h exp=0", bus.PcPlusM); end
    checks++; if (bus.RDM !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", bus.RDM); end
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++; $display("FAIL reset_pcsrc got=%0b exp=0", bus.PCSrcE); end
    rst = 0;
    #1;
    checks++; if (bus.PCSrcE !== 1'b1) begin failures++; $display("FAIL release_pcsrc got=%0b exp=1", bus.PCSrcE); end
    tick();
    checks++; if (bus.RDM !== 5'd9 || bus.PcPlusM !== 32'h44 || bus.Reg_WriteM !== 1'b1 || bus.Mem_WriteM !== 1'b1 || bus.Result_SrcM !== 1'b1)
      begin failures++; $display("FAIL release_capture got rd=%0d pc4=%h rw=%0b mw=%0b rs=%0b exp rd=9 pc4=44 rw=1 mw=1 rs=1", bus.RDM, bus.PcPlusM, bus.Reg_WriteM, bus.Mem_WriteM, bus.Result_SrcM); end
    checks++; if (bus.Write_DataM !== 32'h55 || bus.ALU_ResultM !== 32'h0) begin failures++; $display("FAIL release_data got wd=%h alu=%h exp wd=55 alu=0", bus.Write_DataM, bus.ALU_ResultM); end
  endtask

  task automatic test_add_imm();
    clear_inputs();
    bus.RD1E = 5; bus.Imm_ExE = -32'sd3; bus.ALU_SrcE = 1; bus.RDE = 7; bus.RD2E = 32'hAA;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd2) begin failures++; $display("FAIL add_imm_result got=%h exp=2", bus.ALU_ResultM); end
    checks++; if (bus.RDM !== 5'd7) begin failures++; $display("FAIL add_imm_rd got=%0d exp=7", bus.RDM); end
    checks++; if (bus.Write_DataM !== 32'hAA) begin failures++; $display("FAIL add_imm_wdata got=%h exp=aa", bus.Write_DataM); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.RD1E = 6; bus.RD2E = 4; bus.ALU_ControlE = ALU_ADD;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd10) begin failures++; $display("FAIL fwd_setup got=%h exp=a", bus.ALU_ResultM); end
    bus.ForwardAE = FWD_MEM; bus.RD1E = 99; bus.RD2E = 4; bus.ALU_ControlE = ALU_SUB;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd6) begin failures++; $display("FAIL fwd_mem_a got=%h exp=6", bus.ALU_ResultM); end
    bus.ForwardAE = FWD_REG; bus.ForwardBE = FWD_WB; bus.ResultW = 7; bus.RD1E = 1; bus.RD2E = 32'hDEAD;
    bus.ALU_SrcE = 1; bus.Imm_ExE = 4; bus.Mem_WriteE = 1; bus.ALU_ControlE = ALU_ADD;
    tick();
    checks++; if (bus.Write_DataM !== 32'd7) begin failures++; $display("FAIL fwd_wb_store got=%h exp=7", bus.Write_DataM); end
    checks++; if (bus.ALU_ResultM !== 32'd5 || bus.Mem_WriteM !== 1'b1) begin failures++; $display("FAIL fwd_store_addr got alu=%h mw=%0b exp alu=5 mw=1", bus.ALU_ResultM, bus.Mem_WriteM); end
    bus.ForwardBE = FWD_MEM; bus.ALU_SrcE = 0; bus.ForwardAE = FWD_WB; bus.ResultW = 32'h20;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'h25 || bus.Write_DataM !== 32'd5) begin failures++; $display("FAIL fwd_wb_a_mem_b got alu=%h wd=%h exp alu=25 wd=5", bus.ALU_ResultM, bus.Write_DataM); end
    bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11; bus.RD1E = 32'h100; bus.RD2E = 32'h3;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'h103 || bus.Write_DataM !== 32'h3) begin failures++; $display("FAIL fwd_reserved got alu=%h wd=%h exp alu=103 wd=3", bus.ALU_ResultM, bus.Write_DataM); end
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.BranchE = 1; bus.ALU_ControlE = ALU_SUB; bus.RD1E = 32'h1234; bus.RD2E = 32'h1234;
    bus.PCE = 32'h100; bus.Imm_ExE = -32'sd8; bus.Reg_WriteE = 1; bus.RDE = 5'd3;
    #1;
    checks++; if (bus.PCSrcE !== 1'b1) begin failures++; $display("FAIL branch_taken got=%0b exp=1", bus.PCSrcE); end
    checks++; if (bus.PCTargetE !== 32'hF8) begin failures++; $display("FAIL branch_target got=%h exp=f8", bus.PCTargetE); end
    tick();
    checks++; if (bus.Reg_WriteM !== 1'b1 || bus.RDM !== 5'd3) begin failures++; $display("FAIL branch_keeps_write got rw=%0b rd=%0d exp rw=1 rd=3", bus.Reg_WriteM, bus.RDM); end
    bus.RD2E = 32'h1235;
    #1;
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++; $display("FAIL branch_not_taken got=%0b exp=0", bus.PCSrcE); end
    bus.RD2E = 32'h1234; bus.BranchE = 0;
    #1;
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++; $display("FAIL nonbranch_zero got=%0b exp=0", bus.PCSrcE); end
  endtask

  task automatic test_edges();
    clear_inputs();
    bus.RD1E = 32'h7FFFFFFF; bus.RD2E = 1; bus.ALU_ControlE = ALU_ADD;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'h80000000) begin failures++; $display("FAIL add_overflow got=%h exp=80000000", bus.ALU_ResultM); end
    bus.RD1E = 32'hFFFFFFFF; bus.RD2E = 1; bus.ALU_ControlE = ALU_SLT;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd1) begin failures++; $display("FAIL slt_neg got=%h exp=1", bus.ALU_ResultM); end
    bus.RD1E = 1; bus.RD2E = 32'hFFFFFFFF;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd0) begin failures++; $display("FAIL slt_pos got=%h exp=0", bus.ALU_ResultM); end
    bus.RD1E = 32'hF0F0; bus.RD2E = 32'h0FF0; bus.ALU_ControlE = ALU_AND;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'h00F0) begin failures++; $display("FAIL and_op got=%h exp=f0", bus.ALU_ResultM); end
    bus.ALU_ControlE = ALU_OR;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'hFFF0) begin failures++; $display("FAIL or_op got=%h exp=fff0", bus.ALU_ResultM); end
    bus.ALU_ControlE = 3'b111;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd0) begin failures++; $display("FAIL op_111 got=%h exp=0", bus.ALU_ResultM); end
    bus.ALU_ControlE = 3'b100;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'd0) begin failures++; $display("FAIL op_100 got=%h exp=0", bus.ALU_ResultM); end
    bus.RD1E = 3; bus.RD2E = 5; bus.ALU_ControlE = ALU_SUB;
    tick();
    checks++; if (bus.ALU_ResultM !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_wrap got=%h exp=fffffffe", bus.ALU_ResultM); end
    bus.PCE = 32'hFFFFFFFC; bus.Imm_ExE = 8;
    #1;
    checks++; if (bus.PCTargetE !== 32'd4) begin failures++; $display("FAIL target_wrap got=%h exp=4", bus.PCTargetE); end
  endtask

  task automatic test_midop_reset();
    clear_inputs();
    bus.BranchE = 1; bus.ALU_ControlE = ALU_SUB; bus.RD1E = 32'h77; bus.RD2E = 32'h77;
    bus.Reg_WriteE = 1; bus.Mem_WriteE = 1; bus.RDE = 5'd12; bus.PcPlusE = 32'h204;
    tick();
    checks++; if (bus.RDM !== 5'd12 || bus.PCSrcE !== 1'b1) begin failures++; $display("FAIL midop_pre got rd=%0d pcsrc=%0b exp rd=12 pcsrc=1", bus.RDM, bus.PCSrcE); end
    rst = 1;
    #1;
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++; $display("FAIL midop_pcsrc got=%0b exp=0", bus.PCSrcE); end
    tick();
    checks++; if (bus.RDM !== 5'd0 || bus.Reg_WriteM !== 1'b0 || bus.Mem_WriteM !== 1'b0 || bus.PcPlusM !== 32'h0 || bus.Write_DataM !== 32'h0)
      begin failures++; $display("FAIL midop_flush got rd=%0d rw=%0b mw=%0b pc4=%h wd=%h exp all 0", bus.RDM, bus.Reg_WriteM, bus.Mem_WriteM, bus.PcPlusM, bus.Write_DataM); end
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_add_imm();
    test_forwarding();
    test_branch();
    test_edges();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
